// File: rtl/kernel_loader.sv
// Streaming weight loader: scatters a flat valid/ready word stream across
// NUM kernel banks of DEPTH words. Word k goes to bank k/DEPTH, address k%DEPTH.
module kernel_loader #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 736,
   parameter int NUM    = 512,
   parameter int ADDR_W = 10,
   parameter int BANK_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [WIDTH-1:0]  s_data,
   output logic              s_ready,
   output logic [NUM-1:0]    wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   // state | meaning
   // IDLE  | waiting for start; stream not accepted
   // LOAD  | accepting words, one registered bank write per handshake
   typedef enum logic {IDLE, LOAD} state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_cnt;
   logic [BANK_W-1:0] bank_cnt;
   logic              last_word;
   logic              do_write;
   logic              clr_cnt;
   logic              take_done;
   logic              take_abort;

   assign last_word = (addr_cnt == ADDR_LAST) && (bank_cnt == BANK_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      do_write   = 1'b0;
      clr_cnt    = 1'b0;
      take_done  = 1'b0;
      take_abort = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr_cnt  = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            // abort wins over a same-cycle handshake, including the last word
            if (abort) begin
               take_abort = 1'b1;
               state_nx   = IDLE;
            end else if (s_valid) begin
               do_write = 1'b1;
               if (last_word) begin
                  take_done = 1'b1;
                  state_nx  = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign s_ready = (state == LOAD);
   assign busy    = (state == LOAD);

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         addr_cnt <= '0;
         bank_cnt <= '0;
      end else if (do_write) begin
         if (addr_cnt == ADDR_LAST) begin
            addr_cnt <= '0;
            bank_cnt <= (bank_cnt == BANK_LAST) ? '0 : bank_cnt + 1'b1;
         end else begin
            addr_cnt <= addr_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         for (int i = 0; i < NUM; i++)
            wr_en[i] <= do_write && (bank_cnt == BANK_W'(i));
         if (do_write) begin
            wr_addr <= addr_cnt;
            wr_data <= s_data;
         end
         done    <= take_done;
         aborted <= take_abort;
      end
   end

endmodule

// File: doc/kernel_loader.md
# kernel_loader

Streaming writer for the kernel weight memory banks: it accepts a flat stream of weight words over a valid/ready handshake and scatters them into NUM banks of DEPTH words each. It issues a one-hot per-bank write strobe with a shared address and data bus. Word k of the stream lands in bank k/DEPTH at address k%DEPTH, which is the same flat layout the weight image uses. The block sits between the host/DMA weight stream and the kernel banks, and replaces file-based preload so that weights can be reloaded at run time.

## Interface
- WIDTH, 16, weight word width
- DEPTH, 736, words per bank
- NUM, 512, number of banks
- ADDR_W, 10, bank address width; must satisfy 2^ADDR_W >= DEPTH
- BANK_W, 9, bank index width; must satisfy 2^BANK_W >= NUM
- clk  input  1  clock; all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a full load; sampled in IDLE only
- abort  input  1  terminate the load in progress; sampled in LOAD only
- s_valid  input  1  stream word valid
- s_data  input  WIDTH  stream word
- s_ready  output  1  loader can accept a word
- wr_en  output  NUM  one-hot bank write strobe
- wr_addr  output  ADDR_W  write address, shared by all banks
- wr_data  output  WIDTH  write data, shared by all banks
- busy  output  1  high while in LOAD
- done  output  1  one-cycle pulse when the final word is written
- aborted  output  1  one-cycle pulse when an abort takes effect

## Operation
- FSM states: IDLE, LOAD.
- IDLE:
  - s_ready=0.
  - When start=1: clear bank_cnt and addr_cnt, then go to LOAD.
- LOAD:
  - s_ready=1, busy=1.
  - Each handshake (s_valid & s_ready) registers a write: wr_en[bank_cnt]=1, wr_addr=addr_cnt, wr_data=s_data. Then advance the counters.
  - Counter advance: addr_cnt increments. At DEPTH-1 it wraps to 0 and bank_cnt increments.
  - A handshake at bank_cnt=NUM-1, addr_cnt=DEPTH-1 is the last word. It returns the FSM to IDLE, and done is asserted together with that final write.
- start while in LOAD is ignored.
- abort in LOAD:
  - Returns to IDLE and pulses aborted.
  - A handshake in the same cycle is dropped: no write is issued.
  - abort has priority over completion on the last word.
- abort in IDLE is ignored.
- Gaps in s_valid are allowed. No write is issued in a cycle without a handshake. There is no backpressure from the banks.
- Exactly one wr_en bit is high in a write cycle. All bits are low otherwise.
- Counters never exceed DEPTH-1 and NUM-1. Widths are fixed at ADDR_W and BANK_W.

## Timing
- Reset: state=IDLE, counters=0. On the cycle after rst is sampled high, all outputs are 0: s_ready, wr_en, wr_addr, wr_data, busy, done, aborted.
- rst during LOAD: load is abandoned, no done, no aborted. Banks keep whatever was already written.
- start sampled at edge t: busy=1 and s_ready=1 from t+1.
- Handshake at edge t: wr_en, wr_addr and wr_data are valid for exactly the cycle after t (one-cycle latency). Write outputs are registered.
- Back-to-back handshakes give back-to-back writes; throughput is 1 word/cycle.
- Last-word handshake at edge t: during cycle t+1, done=1 with the final write, busy=0 and s_ready=0.
  - A new start is accepted at edge t+1 at the earliest.
- Abort at edge t: aborted=1, busy=0 and s_ready=0 during cycle t+1.
- Full load takes NUM*DEPTH handshakes. It takes NUM*DEPTH+1 cycles from start with continuous s_valid.

## Test plan
Scenarios 1–5 use DEPTH=4, NUM=3.

1. Continuous load: start, then s_valid=1 with s_data=0..11 on consecutive cycles.
   - Writes go to (bank0,addr0..3)=0..3, (bank1,addr0..3)=4..7, (bank2,addr0..3)=8..11, one per cycle.
   - done pulses with the write of 11. busy falls the same cycle.
2. Bubbly stream: s_valid toggles 1,0,1,0 across 12 words.
   - Writes occur only in cycles following a handshake. Addresses are identical to scenario 1. wr_en is all-zero in gap cycles.
3. Abort with a word pending: abort asserted together with the handshake of word 5.
   - Words 0..4 are written. Word 5 is not written. aborted pulses once, no done.
   - A subsequent start restarts at bank0/addr0.
4. Reset mid-load: rst=1 after word 6.
   - All outputs read 0 next cycle, state=IDLE.
   - start followed by 12 words reproduces scenario 1 exactly.
5. Spurious control:
   - start during LOAD: no counter reset.
   - abort in IDLE: no aborted pulse.
   - s_valid=1 in IDLE: no writes, s_ready=0.
6. Default parameters (WIDTH=16, DEPTH=736, NUM=512), stream word k = k mod 65536.
   - Word 736 writes bank1/addr0 with data 736.
   - Word 376831 writes bank511/addr735 with data 49151 and coincides with done.
